// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the two-port ALU arbiter: FSM state encoding,
// opcode width and the ALU opcodes the arbiter's users most often refer to.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

    localparam int OP_W = 3;

    // Opcodes are passed through untouched; these two are named only because
    // requesters and benches use them for the common add/subtract cases.
    localparam logic [OP_W-1:0] OP_ADD = 3'b100;
    localparam logic [OP_W-1:0] OP_SUB = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage : alu_arbiter_pkg

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the two requester ports, the response/status outputs and the
// external ALU connection of alu_arbiter.
//   slave  : the arbiter (samples requests and ALU results, drives acks,
//            responses, registered ALU operands and statistics)
//   master : the environment (requesters plus the external ALU)
// Parameters: W (operand/result width), CNT_W (statistics counter width).
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) ();
    import alu_arbiter_pkg::*;

    // requester 0
    logic            req0;
    logic [W-1:0]    a0;
    logic [W-1:0]    b0;
    logic [OP_W-1:0] op0;
    // requester 1
    logic            req1;
    logic [W-1:0]    a1;
    logic [W-1:0]    b1;
    logic [OP_W-1:0] op1;
    // completion / response
    logic            ack0;
    logic            ack1;
    logic [W-1:0]    rsp_f;
    logic            rsp_zf;
    logic            rsp_of;
    logic            rsp_id;
    logic            busy;
    // external ALU
    logic [W-1:0]    alu_a;
    logic [W-1:0]    alu_b;
    logic [OP_W-1:0] alu_op;
    logic [W-1:0]    alu_f;
    logic            alu_zf;
    logic            alu_of;
    // statistics
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] of_cnt;

    modport slave (
        input  req0, a0, b0, op0,
        input  req1, a1, b1, op1,
        input  alu_f, alu_zf, alu_of,
        output ack0, ack1, rsp_f, rsp_zf, rsp_of, rsp_id, busy,
        output alu_a, alu_b, alu_op,
        output cnt0, cnt1, of_cnt
    );

    modport master (
        output req0, a0, b0, op0,
        output req1, a1, b1, op1,
        output alu_f, alu_zf, alu_of,
        input  ack0, ack1, rsp_f, rsp_zf, rsp_of, rsp_id, busy,
        input  alu_a, alu_b, alu_op,
        input  cnt0, cnt1, of_cnt
    );

endinterface : alu_arbiter_if

// File: rtl/alu_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker.
//   req[1:0]  : in  request vector (bit n = port n)
//   last      : in  port that completed most recently
//   gnt_valid : out at least one request is present
//   gid       : out granted port (meaningful only when gnt_valid=1)
// A lone request is always granted; on a tie the port that did not complete
// last wins.
// -----------------------------------------------------------------------------
module rr_arb2
    import alu_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gid
);

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_valid = |req;
        gid       = 1'b0;
        if (req == 2'b11) begin
            gid = ~last;
        end else begin
            gid = req[1];
        end
    end

endmodule : rr_arb2

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one external ALU between two requesters. A round-robin winner is
// picked in IDLE and its operands are registered onto alu_a/alu_b/alu_op; the
// ALU evaluates during EXEC and its result and flags are captured into rsp_*;
// RESP raises the winner's ack for one cycle. One op per three cycles.
//
// Ports:
//   clk  : in  system clock
//   rst  : in  synchronous active-high reset
//   bus  : alu_arbiter_if.slave (requesters, acks, responses, busy,
//          ALU operands/results, statistics counters)
//
// Build option: define ALU_ARB_STATS_EN to enable the saturating per-port
// completion counters (cnt0/cnt1) and the overflow counter (of_cnt). When it
// is undefined those outputs are tied to zero.
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    alu_arbiter_if.slave bus
);

    state_t          state;
    state_t          state_nx;
    logic            gnt_valid;
    logic            gid;
    logic            gid_q;      // port currently being served
    logic            last_q;     // port that completed most recently
    logic            load_ops;
    logic            capture;
    logic            complete;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [OP_W-1:0] sel_op;

    rr_arb2 u_rr_arb2 (
        .req       ({bus.req1, bus.req0}),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gid       (gid)
    );

    // NOTE: state and datapath registers use non-blocking assignments so all
    // of them update together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load_ops = 1'b0;
        capture  = 1'b0;
        complete = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (gnt_valid) begin
                    load_ops = 1'b1;
                    state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                capture  = 1'b1;
                state_nx = ST_RESP;
            end
            ST_RESP: begin
                complete = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Winner's operands, muxed ahead of the operand registers.
    assign sel_a  = gid ? bus.a1  : bus.a0;
    assign sel_b  = gid ? bus.b1  : bus.b0;
    assign sel_op = gid ? bus.op1 : bus.op0;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.alu_a  <= '0;
            bus.alu_b  <= '0;
            bus.alu_op <= '0;
            bus.rsp_f  <= '0;
            bus.rsp_zf <= 1'b0;
            bus.rsp_of <= 1'b0;
            bus.rsp_id <= 1'b0;
            bus.ack0   <= 1'b0;
            bus.ack1   <= 1'b0;
            gid_q      <= 1'b0;
            // Port 0 wins the first tie after reset.
            last_q     <= 1'b1;
        end else begin
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            if (load_ops) begin
                gid_q      <= gid;
                bus.alu_a  <= sel_a;
                bus.alu_b  <= sel_b;
                bus.alu_op <= sel_op;
            end
            // Ack is set on the EXEC->RESP edge so it is high exactly during
            // RESP, alongside the freshly captured response.
            if (capture) begin
                bus.rsp_f  <= bus.alu_f;
                bus.rsp_zf <= bus.alu_zf;
                bus.rsp_of <= bus.alu_of;
                bus.rsp_id <= gid_q;
                bus.ack0   <= ~gid_q;
                bus.ack1   <= gid_q;
            end
            // Fairness pointer moves only when an op really completes, so an
            // aborted op does not cost its port a turn.
            if (complete) begin
                last_q <= gid_q;
            end
        end
    end

    assign bus.busy = (state != ST_IDLE);

`ifdef ALU_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;
    logic [CNT_W-1:0] of_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q   <= '0;
            cnt1_q   <= '0;
            of_cnt_q <= '0;
        end else if (complete) begin
            if (!gid_q && cnt0_q != CNT_MAX) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (gid_q && cnt1_q != CNT_MAX) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
            if (bus.rsp_of && of_cnt_q != CNT_MAX) begin
                of_cnt_q <= of_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.cnt0   = cnt0_q;
    assign bus.cnt1   = cnt1_q;
    assign bus.of_cnt = of_cnt_q;
`else
    assign bus.cnt0   = {CNT_W{1'b0}};
    assign bus.cnt1   = {CNT_W{1'b0}};
    assign bus.of_cnt = {CNT_W{1'b0}};
`endif

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. Provides the external ALU, drives two
// requesters and compares every cycle against a transaction-level reference
// model, plus directed expectations for the single-op, contention, overflow,
// zero-flag, mid-op reset and statistics scenarios. Honours ALU_ARB_STATS_EN.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int W       = 32;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    alu_arbiter_if #(.W(W), .CNT_W(CNT_W)) bus ();

    alu_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: result, zero flag, signed overflow flag.
    function automatic logic [W+1:0] alu_eval(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [2:0] op);
        logic [W-1:0] f;
        logic         ovf;
        f   = '0;
        ovf = 1'b0;
        case (op)
            3'b000: f = a & b;
            3'b001: f = a | b;
            3'b010: f = a ^ b;
            3'b011: f = ~(a | b);
            3'b100: begin
                f   = a + b;
                ovf = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]);
            end
            3'b101: begin
                f   = a - b;
                ovf = (a[W-1] != b[W-1]) && (f[W-1] != a[W-1]);
            end
            3'b110: f = a << b[4:0];
            default: f = a;
        endcase
        return {f, (f == '0), ovf};
    endfunction

    assign {bus.alu_f, bus.alu_zf, bus.alu_of} = alu_eval(bus.alu_a, bus.alu_b, bus.alu_op);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Transaction view: an op occupies three cycles from its grant (grant,
    // evaluate, respond); the response becomes visible with the ack.
    int           m_phase;   // 0 free, 1 operands loaded, 2 responding
    logic         m_gid, m_last;
    logic [W-1:0] m_a, m_b, m_f;
    logic [2:0]   m_op;
    logic         m_zf, m_of, m_id, m_ack0, m_ack1;
    int           m_c0, m_c1, m_co;

    initial begin : monitor
        logic [W+1:0] res;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_phase = 0; m_gid = 1'b0; m_last = 1'b1;
                m_a = '0; m_b = '0; m_op = '0; m_f = '0;
                m_zf = 1'b0; m_of = 1'b0; m_id = 1'b0; m_ack0 = 1'b0; m_ack1 = 1'b0;
                m_c0 = 0; m_c1 = 0; m_co = 0;
            end else if (m_phase == 0) begin
                if (bus.req0 || bus.req1) begin
                    m_gid   = (bus.req0 && bus.req1) ? !m_last : bus.req1;
                    m_a     = m_gid ? bus.a1  : bus.a0;
                    m_b     = m_gid ? bus.b1  : bus.b0;
                    m_op    = m_gid ? bus.op1 : bus.op0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                res = alu_eval(m_a, m_b, m_op);
                {m_f, m_zf, m_of} = res;
                m_id    = m_gid;
                m_ack0  = !m_gid;
                m_ack1  = m_gid;
                m_phase = 2;
            end else begin
                m_ack0 = 1'b0;
                m_ack1 = 1'b0;
                m_last = m_gid;
`ifdef ALU_ARB_STATS_EN
                if (!m_gid && m_c0 < CNT_MAX) m_c0++;
                if (m_gid && m_c1 < CNT_MAX) m_c1++;
                if (m_of && m_co < CNT_MAX) m_co++;
`endif
                m_phase = 0;
            end
            @(negedge clk);
            check("ack0",   bus.ack0,   m_ack0);
            check("ack1",   bus.ack1,   m_ack1);
            check("ack_excl", bus.ack0 & bus.ack1, 1'b0);
            check("busy",   bus.busy,   m_phase != 0);
            check("alu_a",  bus.alu_a,  m_a);
            check("alu_b",  bus.alu_b,  m_b);
            check("alu_op", bus.alu_op, m_op);
            check("rsp_f",  bus.rsp_f,  m_f);
            check("rsp_zf", bus.rsp_zf, m_zf);
            check("rsp_of", bus.rsp_of, m_of);
            check("rsp_id", bus.rsp_id, m_id);
            check("cnt0",   bus.cnt0,   m_c0);
            check("cnt1",   bus.cnt1,   m_c1);
            check("of_cnt", bus.of_cnt, m_co);
        end
    end

    // -------------------------------------------------------------- drivers
    task automatic set_port(input int p, input logic r, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [2:0] op);
        if (p == 0) begin
            bus.req0 = r; bus.a0 = a; bus.b0 = b; bus.op0 = op;
        end else begin
            bus.req1 = r; bus.a1 = a; bus.b1 = b; bus.op1 = op;
        end
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one op from an idle arbiter and wait (bounded) for its ack.
    // lat counts cycles from the IDLE sample to the ack; -1 on timeout.
    task automatic do_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, output logic [W-1:0] f,
                         output logic zf, output logic of, output logic id, output int lat);
        @(negedge clk);
        set_port(p, 1'b1, a, b, op);
        lat = -1; f = '0; zf = 1'b0; of = 1'b0; id = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((p == 0) ? bus.ack0 : bus.ack1) begin
                lat = i; f = bus.rsp_f; zf = bus.rsp_zf; of = bus.rsp_of; id = bus.rsp_id;
                break;
            end
        end
        set_port(p, 1'b0, a, b, op);
    endtask

    // Wait (bounded) for whichever ack comes next; p = -1 on timeout.
    task automatic wait_ack(output int p, output logic [W-1:0] f);
        p = -1; f = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                p = bus.ack1 ? 1 : 0;
                f = bus.rsp_f;
                break;
            end
        end
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin : stimulus
        logic [W-1:0] f;
        logic         zf, of, id;
        int           lat, p;
        int           order[4];
        int           done;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        set_port(0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single op on port 0.
        do_op(0, 32'h3, 32'h607, OP_ADD, f, zf, of, id, lat);
        check("single_lat", lat, 2);
        check("single_f",   f,   32'h60A);
        check("single_zf",  zf,  1'b0);
        check("single_of",  of,  1'b0);
        check("single_id",  id,  1'b0);
        @(negedge clk);
        check("single_ack_width", bus.ack0, 1'b0);

        // Contention from reset: both held, completion order alternates.
        pulse_reset();
        set_port(0, 1'b1, 32'd10, 32'd1, OP_ADD);
        set_port(1, 1'b1, 32'd20, 32'd2, OP_SUB);
        done = 0;
        for (int i = 0; i < 40 && done < 4; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                order[done] = bus.ack1 ? 1 : 0;
                if (bus.ack0) set_port(0, 1'b1, 32'(i), 32'd3, OP_ADD);
                else          set_port(1, 1'b1, 32'(i), 32'd4, OP_SUB);
                done++;
            end
        end
        set_port(0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, '0, '0, '0);
        check("contend_done", done, 4);
        for (int k = 0; k < 4; k++) check($sformatf("contend_order%0d", k), order[k], k % 2);

        // Signed overflow on port 1.
        do_op(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, OP_ADD, f, zf, of, id, lat);
        check("ovf_f",  f,  32'hFFFF_FFFE);
        check("ovf_of", of, 1'b1);
        check("ovf_id", id, 1'b1);

        // Zero flag on port 0.
        do_op(0, 32'h8000_0000, 32'h8000_0000, OP_SUB, f, zf, of, id, lat);
        check("zero_f",  f,  32'h0);
        check("zero_zf", zf, 1'b1);
        check("zero_of", of, 1'b0);

        // Reset during EXEC, then both ports reissue: port 0 must win.
        @(negedge clk);
        set_port(0, 1'b1, 32'd5, 32'd3, OP_SUB);
        set_port(1, 1'b1, 32'd9, 32'd1, OP_ADD);
        @(negedge clk);
        check("midrst_busy", bus.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_acks",  {bus.ack1, bus.ack0}, 2'b00);
        check("midrst_busy0", bus.busy,  1'b0);
        check("midrst_f",     bus.rsp_f, 32'h0);
        check("midrst_alu_a", bus.alu_a, 32'h0);
        rst = 1'b0;
        wait_ack(p, f);
        check("reissue_first", p, 0);
        check("reissue_f0",    f, 32'd2);
        set_port(0, 1'b0, 32'd5, 32'd3, OP_SUB);
        wait_ack(p, f);
        check("reissue_second", p, 1);
        check("reissue_f1",     f, 32'd10);
        set_port(1, 1'b0, 32'd9, 32'd1, OP_ADD);

        // Statistics: three ops on port 0, two on port 1, one overflowing.
        pulse_reset();
        do_op(0, 32'd1, 32'd2, OP_ADD, f, zf, of, id, lat);
        do_op(1, 32'h7FFF_FFFF, 32'd1, OP_ADD, f, zf, of, id, lat);
        do_op(0, 32'd4, 32'd4, OP_SUB, f, zf, of, id, lat);
        do_op(1, 32'hF0, 32'h0F, 3'b010, f, zf, of, id, lat);
        do_op(0, 32'hA0, 32'h05, 3'b001, f, zf, of, id, lat);
        @(negedge clk);
`ifdef ALU_ARB_STATS_EN
        check("stats_cnt0",   bus.cnt0,   3);
        check("stats_cnt1",   bus.cnt1,   2);
        check("stats_of_cnt", bus.of_cnt, 1);
`else
        check("stats_cnt0",   bus.cnt0,   0);
        check("stats_cnt1",   bus.cnt1,   0);
        check("stats_of_cnt", bus.of_cnt, 0);
`endif

        // Randomized traffic with occasional resets; the model checks it all.
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic r, k;
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 79) == 0) rst = 1'b1;
            for (int q = 0; q < 2; q++) begin
                r = (q == 0) ? bus.req0 : bus.req1;
                k = (q == 0) ? bus.ack0 : bus.ack1;
                if (r && k) begin
                    if ($urandom_range(0, 1) == 0)
                        set_port(q, 1'b0, rand_opnd(), rand_opnd(), 3'($urandom_range(0, 7)));
                    else
                        set_port(q, 1'b1, rand_opnd(), rand_opnd(), 3'($urandom_range(0, 7)));
                end else if (!r && $urandom_range(0, 2) == 0) begin
                    set_port(q, 1'b1, rand_opnd(), rand_opnd(), 3'($urandom_range(0, 7)));
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        set_port(0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, '0, '0, '0);
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu_arbiter

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU instance between two requesters, e.g. an automatic test sequencer (port 0) and the board-switch operand path (port 1).
- Round-robin grant, registered operands into the ALU, registered result with a one-cycle ack pulse.
- Sits between requesters and ALU; the ALU is instantiated outside this block and connected via the alu_* ports.

Parameters:
- W, 32, operand/result width
- CNT_W, 16, width of statistics counters (only used with ALU_ARB_STATS_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0  in  1  requester 0 request; held until ack0
- a0, b0  in  W  requester 0 operands; stable while req0=1
- op0  in  3  requester 0 ALU opcode
- req1, a1, b1, op1  in  1/W/W/3  requester 1, same rules
- ack0, ack1  out  1  one-cycle completion pulse
- rsp_f  out  W  result of last completed op
- rsp_zf, rsp_of  out  1  flags of last completed op
- rsp_id  out  1  requester of last completed op
- busy  out  1  high in EXEC or RESP
- alu_a, alu_b  out  W  registered operands to ALU
- alu_op  out  3  registered opcode to ALU
- alu_f  in  W  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_zf, alu_of  in  1  ALU flags
- cnt0, cnt1, of_cnt  out  CNT_W  statistics (see Optional Feature)

Behaviour:
- Decided: one clock clk; rst synchronous, active-high. All state changes on posedge clk.
- Reset values: state=IDLE, ack0/ack1=0, rsp_f=0, rsp_zf=0, rsp_of=0, rsp_id=0, busy=0, alu_a/alu_b=0, alu_op=0, last=1 (port 0 wins first tie), counters=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req, pick winner, latch its a/b/op into alu_a/alu_b/alu_op and gid, go EXEC; else stay.
- EXEC: ALU evaluates; at end of cycle capture alu_f/alu_zf/alu_of/gid into rsp_*, go RESP.
- RESP: ack[gid]=1 for exactly this cycle; last<=gid; go IDLE.
- Latency: req sampled in IDLE cycle n, ack in cycle n+2; rsp_* valid from cycle n+2 and held until the next RESP. Throughput: one op per 3 cycles.
- Arbitration:
  - only one req: grant it;
  - both: grant the port != last;
  - last updates only on completion.
- Handshake: requester holds req and operands until it sees ack, then drops req at that clock edge. A req still high in the IDLE cycle after ack is treated as a new request.
- Operands are sampled only in IDLE; changes while busy are ignored.
- Opcodes are passed through unchanged; all 8 are legal.
- Reset mid-operation (EXEC or RESP): the op is aborted, no ack is issued, all outputs return to reset values, and the requester must reissue.
- Flags are taken from the ALU only; the arbiter never recomputes them.

Optional Feature:
- ALU_ARB_STATS_EN defined:
  - cnt0/cnt1 increment in RESP for the completed port;
  - of_cnt increments in RESP when the captured OF=1;
  - all counters saturate at 2^CNT_W-1 and clear on rst.
- Undefined: counter logic is omitted and cnt0/cnt1/of_cnt are tied to 0. Port list is unchanged.

Decomposition:
- Shared include alu_arb_defs.vh: state encodings (IDLE=2'd0, EXEC=2'd1, RESP=2'd2), opcode width 3, ALU opcode constants (ADD=3'b100, SUB=3'b101).
- One sub-module, rr_arb2: combinational 2-way round-robin picker. Inputs req[1:0] and last; outputs gnt_valid and gid.

Test Plan:
- Single op: req0, a0=32'h3, b0=32'h607, op ADD → ack0 two cycles after first IDLE sample; rsp_f=32'h60A, zf=0, of=0, rsp_id=0; ack0 high exactly 1 cycle.
- Contention after reset: req0 and req1 held continuously, 4 ops → completion order 0,1,0,1; never two acks in one cycle; busy low only in IDLE cycles.
- Overflow: a1=b1=32'h7FFF_FFFF, op ADD → rsp_f=32'hFFFF_FFFE, rsp_of=1, rsp_id=1.
- Zero flag: a0=b0=32'h8000_0000, op SUB → rsp_f=0, rsp_zf=1, rsp_of=0.
- Reset mid-op: rst pulsed in EXEC → no ack, all outputs 0 next cycle; reissued op completes with correct result and port 0 winning the next tie.
- Stats: with ALU_ARB_STATS_EN, 3 ops on port 0, 2 on port 1, one of them overflowing → cnt0=3, cnt1=2, of_cnt=1. Without the macro, all counters stay 0.
